// File: rtl/axi_sram_responder_pkg.sv
// Shared types for the AXI SRAM responder: burst length, FSM states, arbitration memory.
package axi_sram_responder_pkg;

    localparam int unsigned AXI_DATA_WIDTH_DEF = 32;
    localparam int unsigned AXI_ADDR_WIDTH_DEF = 32;

    typedef logic [7:0] axi_burst_len_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_DATA,
        WRITE_RESP,
        READ_FETCH,
        READ_DATA
    } axi_responder_state_t;

    typedef enum logic {
        SERVED_READ,
        SERVED_WRITE
    } axi_dir_t;

endpackage

// File: rtl/axi_sram_responder_sram.sv
// Single-port-read / single-port-write SRAM with registered read data; array is not reset.
module sram_1r1w
    import axi_sram_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH_DEF,
    parameter int unsigned SIZE       = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(SIZE)-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(SIZE)-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [SIZE];

    // Write port: one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: output register only changes on an enabled read, so data holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave backed by an internal word-addressed SRAM; serves one INCR burst at a time.
module axi_sram_responder
    import axi_sram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
    parameter int unsigned AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    input  logic [7:0]                m_awlen,
    input  logic [2:0]                m_awprot,
    input  logic                      m_awvalid,
    output logic                      s_awready,
    input  logic [AXI_DATA_WIDTH-1:0] m_wdata,
    input  logic                      m_wlast,
    input  logic                      m_wvalid,
    output logic                      s_wready,
    output logic                      s_bvalid,
    input  logic                      m_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    input  logic [7:0]                m_arlen,
    input  logic [2:0]                m_arprot,
    input  logic                      m_arvalid,
    output logic                      s_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_rdata,
    output logic                      s_rvalid,
    input  logic                      m_rready,
    output logic                      protocol_error
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned OFF_W = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    axi_responder_state_t state;
    axi_dir_t             last_served;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    axi_burst_len_t       beats;
    logic [IDX_W-1:0]     aw_word;
    logic [IDX_W-1:0]     ar_word;
    logic                 grant_write;
    logic                 grant_read;
    logic                 aw_hs;
    logic                 ar_hs;
    logic                 w_hs;
    logic                 r_hs;
    logic                 mem_we;
    logic                 mem_re;
    logic [IDX_W-1:0]     mem_raddr;

    // Protection bits and the aliased upper address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{m_awprot, m_arprot, m_awaddr, m_araddr};

    assign aw_word  = m_awaddr[IDX_W+OFF_W-1:OFF_W];
    assign ar_word  = m_araddr[IDX_W+OFF_W-1:OFF_W];
    assign idx_next = idx + IDX_ONE;

    // Round-robin grant between the address channels; ties go opposite to the last burst type.
    always_comb begin
        grant_write = m_awvalid && (!m_arvalid || (last_served == SERVED_READ));
        grant_read  = m_arvalid && (!m_awvalid || (last_served == SERVED_WRITE));
    end

    assign s_awready = (state == IDLE) && grant_write;
    assign s_arready = (state == IDLE) && grant_read;
    assign aw_hs     = s_awready && m_awvalid;
    assign ar_hs     = s_arready && m_arvalid;
    assign w_hs      = s_wready && m_wvalid;
    assign r_hs      = s_rvalid && m_rready;

    // SRAM port control: fetch the first word, then prefetch the next one on each accepted beat.
    always_comb begin
        mem_we    = w_hs;
        mem_re    = 1'b0;
        mem_raddr = idx;
        if (state == READ_FETCH) begin
            mem_re = 1'b1;
        end else if ((state == READ_DATA) && r_hs && (beats != '0)) begin
            mem_re    = 1'b1;
            mem_raddr = idx_next;
        end
    end

    sram_1r1w #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .SIZE       (MEM_WORDS)
    ) u_sram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (mem_we),
        .wr_addr (idx),
        .wr_data (m_wdata),
        .rd_en   (mem_re),
        .rd_addr (mem_raddr),
        .rd_data (s_rdata)
    );

    // Burst sequencer with registered channel handshake outputs and sticky WLAST check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_served    <= SERVED_READ;
            idx            <= '0;
            beats          <= '0;
            s_wready       <= 1'b0;
            s_bvalid       <= 1'b0;
            s_rvalid       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        state       <= WRITE_DATA;
                        idx         <= aw_word;
                        beats       <= m_awlen;
                        last_served <= SERVED_WRITE;
                        s_wready    <= 1'b1;
                    end else if (ar_hs) begin
                        state       <= READ_FETCH;
                        idx         <= ar_word;
                        beats       <= m_arlen;
                        last_served <= SERVED_READ;
                    end
                end
                WRITE_DATA: begin
                    if (w_hs) begin
                        idx   <= idx_next;
                        beats <= beats - 8'd1;
                        if (m_wlast != (beats == '0)) begin
                            protocol_error <= 1'b1;
                        end
                        if (beats == '0) begin
                            state    <= WRITE_RESP;
                            s_wready <= 1'b0;
                            s_bvalid <= 1'b1;
                        end
                    end
                end
                WRITE_RESP: begin
                    if (m_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                READ_FETCH: begin
                    state    <= READ_DATA;
                    s_rvalid <= 1'b1;
                end
                READ_DATA: begin
                    if (r_hs) begin
                        if (beats == '0) begin
                            s_rvalid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx_next;
                            beats <= beats - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized bench for axi_sram_responder against a transaction-level memory model.
module tb_axi_sram_responder;

    localparam int unsigned MEM_WORDS = 16;
    localparam int unsigned BOUND     = 2000;

    logic        clk;
    logic        reset_n;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        s_awready;
    logic [31:0] m_wdata;
    logic        m_wlast;
    logic        m_wvalid;
    logic        s_wready;
    logic        s_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        m_rready;
    logic        protocol_error;

    axi_sram_responder #(
        .MEM_WORDS      (MEM_WORDS),
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m_awaddr       (m_awaddr),
        .m_awlen        (m_awlen),
        .m_awprot       (m_awprot),
        .m_awvalid      (m_awvalid),
        .s_awready      (s_awready),
        .m_wdata        (m_wdata),
        .m_wlast        (m_wlast),
        .m_wvalid       (m_wvalid),
        .s_wready       (s_wready),
        .s_bvalid       (s_bvalid),
        .m_bready       (m_bready),
        .m_araddr       (m_araddr),
        .m_arlen        (m_arlen),
        .m_arprot       (m_arprot),
        .m_arvalid      (m_arvalid),
        .s_arready      (s_arready),
        .s_rdata        (s_rdata),
        .s_rvalid       (s_rvalid),
        .m_rready       (m_rready),
        .protocol_error (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] wbuf [256];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    bit          perr_exp;
    bit          last_was_write;
    bit          prev_hold;
    logic [31:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within %0d cycles", name, BOUND);
    endtask

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a >> 2) % MEM_WORDS;
    endfunction

    function automatic logic [31:0] got_at(input int unsigned i);
        if (got_q.size() > i) return got_q[i];
        return 'x;
    endfunction

    // Per-cycle compare against the model: read data order, hold-under-backpressure, arbitration, sticky error.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold      = 1'b0;
            last_was_write = 1'b0;
        end else begin
            chk("ready_exclusive", {31'd0, s_awready && s_arready}, 32'd0);
            if (m_awvalid && m_arvalid && (s_awready || s_arready)) begin
                chk("arb_alternation", {31'd0, s_awready}, {31'd0, !last_was_write});
            end
            if (s_awready && m_awvalid) last_was_write = 1'b1;
            else if (s_arready && m_arvalid) last_was_write = 1'b0;
            chk("protocol_error", {31'd0, protocol_error}, {31'd0, perr_exp});
            if (prev_hold) begin
                chk("rvalid_held", {31'd0, s_rvalid}, 32'd1);
                chk("rdata_held", s_rdata, prev_data);
            end
            if (s_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", {31'd0, s_rvalid}, 32'd0);
                end else begin
                    chk("rdata", s_rdata, exp_q[0]);
                    if (m_rready) begin
                        got_q.push_back(s_rdata);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_hold = s_rvalid && !m_rready;
            prev_data = s_rdata;
        end
    end

    task automatic do_write(input logic [31:0] addr, input int unsigned len, input bit bad_last,
                            output int unsigned aw_wait);
        int unsigned base;
        int unsigned beat;
        int unsigned t;
        bit hs;
        base = word_of(addr);
        aw_wait = 0;
        @(posedge clk); #1;
        m_awaddr  = addr;
        m_awlen   = len[7:0];
        m_awvalid = 1'b1;
        forever begin
            @(negedge clk);
            chk("wready_outside_burst", {31'd0, s_wready}, 32'd0);
            if (s_awready) break;
            aw_wait++;
            if (aw_wait > BOUND) begin
                timeout("aw_handshake");
                m_awvalid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        m_awvalid = 1'b0;
        beat = 0;
        t = 0;
        while (beat <= len) begin
            m_wvalid = ($urandom_range(0, 3) != 0);
            m_wdata  = wbuf[beat];
            m_wlast  = bad_last ? (beat == 0) : (beat == len);
            @(negedge clk);
            hs = m_wvalid && s_wready;
            @(posedge clk); #1;
            if (hs) begin
                model_mem[(base + beat) % MEM_WORDS] = wbuf[beat];
                if (m_wlast != (beat == len)) perr_exp = 1'b1;
                beat++;
            end else begin
                t++;
                if (t > BOUND) begin
                    timeout("w_handshake");
                    m_wvalid = 1'b0;
                    return;
                end
            end
        end
        m_wvalid = 1'b0;
        m_wlast  = 1'b0;
        @(negedge clk);
        chk("bvalid_after_last_w", {31'd0, s_bvalid}, 32'd1);
        chk("wready_after_last_w", {31'd0, s_wready}, 32'd0);
        t = 0;
        forever begin
            @(posedge clk); #1;
            m_bready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            chk("bvalid_held", {31'd0, s_bvalid}, 32'd1);
            if (m_bready && s_bvalid) begin
                @(posedge clk); #1;
                m_bready = 1'b0;
                break;
            end
            t++;
            if (t > BOUND) begin
                timeout("b_handshake");
                m_bready = 1'b0;
                return;
            end
        end
    endtask

    // mode 0: random rready, 1: 1,0,0,1 pattern from the first valid beat, 2: always ready
    task automatic do_read(input logic [31:0] addr, input int unsigned len, input int unsigned mode,
                           output int unsigned ar_wait);
        int unsigned base;
        int unsigned cyc;
        base = word_of(addr);
        ar_wait = 0;
        @(posedge clk); #1;
        m_araddr  = addr;
        m_arlen   = len[7:0];
        m_arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_arready) break;
            ar_wait++;
            if (ar_wait > BOUND) begin
                timeout("ar_handshake");
                m_arvalid = 1'b0;
                return;
            end
        end
        for (int unsigned b = 0; b <= len; b++) begin
            exp_q.push_back(model_mem[(base + b) % MEM_WORDS]);
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0) begin
            case (mode)
                0: m_rready = ($urandom_range(0, 3) != 0);
                1: m_rready = (((cyc + 3) % 4) == 0) || (((cyc + 3) % 4) == 3);
                default: m_rready = 1'b1;
            endcase
            @(negedge clk);
            if (cyc == 0) chk("rvalid_latency_c1", {31'd0, s_rvalid}, 32'd0);
            if (cyc == 1) chk("rvalid_latency_c2", {31'd0, s_rvalid}, 32'd1);
            @(posedge clk); #1;
            cyc++;
            if (cyc > BOUND) begin
                timeout("r_beats");
                exp_q.delete();
                break;
            end
        end
        m_rready = 1'b0;
        @(negedge clk);
        chk("rvalid_drop_after_last", {31'd0, s_rvalid}, 32'd0);
    endtask

    initial begin
        int unsigned w;
        int unsigned r;
        int unsigned w2;
        int unsigned r2;
        int unsigned t;
        int unsigned kind;
        int unsigned len;
        logic [31:0] a;
        logic [31:0] a2;

        reset_n   = 1'b0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awprot  = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arprot  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        perr_exp  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl_outputs",
            {25'd0, s_awready, s_arready, s_wready, s_bvalid, s_rvalid, protocol_error, 1'b0}, 32'd0);
        chk("reset_rdata", s_rdata, 32'd0);
        reset_n = 1'b1;

        // Both address channels together out of reset: write wins, read follows.
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        fork
            do_write(32'h0, 15, 1'b0, w);
            do_read(32'h0, 15, 0, r);
        join
        chk("arb_reset_write_first", w, 32'd0);
        chk("arb_reset_read_waits", {31'd0, r != 0}, 32'd1);

        // After a write, a simultaneous pair grants the read.
        wbuf[0] = 32'h0000_1357;
        do_write(32'h4, 0, 1'b0, w);
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        fork
            do_write(32'h8, 2, 1'b0, w2);
            do_read(32'h0, 3, 0, r2);
        join
        chk("arb_after_write_read_first", r2, 32'd0);
        chk("arb_after_write_write_waits", {31'd0, w2 != 0}, 32'd1);

        // Single beat write then read.
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(32'h40, 0, 1'b0, w);
        got_q.delete();
        do_read(32'h40, 0, 2, r);
        chk("single_count", got_q.size(), 32'd1);
        chk("single_data", got_at(0), 32'hDEAD_BEEF);

        // Four beats with 1,0,0,1 backpressure.
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(32'h100, 3, 1'b0, w);
        got_q.delete();
        do_read(32'h100, 3, 1, r);
        chk("burst4_count", got_q.size(), 32'd4);
        chk("burst4_beat0", got_at(0), 32'd1);
        chk("burst4_beat1", got_at(1), 32'd2);
        chk("burst4_beat2", got_at(2), 32'd3);
        chk("burst4_beat3", got_at(3), 32'd4);

        // Wrap past the top of a 16-word memory.
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        do_write(32'h38, 3, 1'b0, w);
        got_q.delete();
        do_read(32'h0, 0, 2, r);
        chk("wrap_word0", got_at(0), 32'hC);
        got_q.delete();
        do_read(32'h38, 3, 0, r);
        chk("wrap_word14", got_at(0), 32'hA);
        chk("wrap_word15", got_at(1), 32'hB);
        chk("wrap_word1", got_at(3), 32'hD);

        // Early WLAST: error is flagged and sticky, burst still runs to its count.
        chk("perr_before", {31'd0, protocol_error}, 32'd0);
        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        do_write(32'h20, 1, 1'b1, w);
        chk("perr_after", {31'd0, protocol_error}, 32'd1);
        got_q.delete();
        do_read(32'h20, 1, 2, r);
        chk("perr_burst_beat1", got_at(1), 32'h22);

        // Longest burst.
        for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
        a = $urandom;
        do_write(a, 255, 1'b0, w);
        do_read(a + 32'h10, 255, 0, r);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            len  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
            a    = $urandom;
            a2   = $urandom;
            for (int i = 0; i <= 40; i++) wbuf[i] = $urandom;
            case (kind)
                0, 1: do_write(a, len, 1'b0, w);
                2: do_read(a, len, $urandom_range(0, 2), r);
                default: begin
                    fork
                        do_write(a, len, 1'b0, w);
                        do_read(a2, $urandom_range(0, 6), 0, r);
                    join
                end
            endcase
        end

        // Reset while the third beat of an 8-beat read is on the bus.
        a = $urandom;
        @(posedge clk); #1;
        m_araddr  = a;
        m_arlen   = 8'd7;
        m_arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_arready && t < BOUND);
        if (!s_arready) timeout("midreset_ar");
        for (int unsigned b = 0; b < 8; b++) exp_q.push_back(model_mem[(word_of(a) + b) % MEM_WORDS]);
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        m_rready  = 1'b1;
        t = 0;
        while (exp_q.size() > 6 && t < BOUND) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= BOUND) timeout("midreset_beats");
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("midreset_rdata", s_rdata, 32'd0);
        chk("midreset_perr", {31'd0, protocol_error}, 32'd0);
        exp_q.delete();
        m_rready = 1'b0;
        perr_exp = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        got_q.delete();
        do_read(32'h40, 3, 2, r);
        chk("ar_first_cycle_after_reset", r, 32'd0);
        chk("after_reset_count", got_q.size(), 32'd4);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i <= 8; i++) wbuf[i] = $urandom;
            a  = $urandom;
            a2 = $urandom;
            fork
                do_write(a, $urandom_range(0, 8), 1'b0, w);
                do_read(a2, $urandom_range(0, 8), 0, r);
            join
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
